// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Configurable UART receiver. The serial line is oversampled on an external
// baud_en tick (OVERSAMPLE ticks per bit), deserialized LSB-first, and the
// optional parity bit and one or two stop bits are checked. Frame format is
// captured when a start edge is detected and stays fixed for that frame.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   baud_en     one-clk oversample tick at OVERSAMPLE x bit rate
//   rx_in       serial line, idle high, asynchronous to clk
//   data_bits   00=5, 01=6, 10=7, 11=8 data bits
//   parity_en   1 = parity bit present
//   parity_sel  0 = odd, 1 = even
//   stop_bits   0 = one, 1 = two stop bits
//   rx_data     last received word, zero above the data width
//   rx_ready    one-clk pulse when a frame completes
//   rx_error    parity_err | frame_err of the last frame
//   parity_err  last frame failed its parity check
//   frame_err   a sampled stop bit of the last frame was 0
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_en,
   input  logic       rx_in,
   input  logic [1:0] data_bits,
   input  logic       parity_en,
   input  logic       parity_sel,
   input  logic       stop_bits,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       rx_error,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_DONE,
      S_BREAK
   } state_t;

   // Two-stage synchronizer; idles high so reset never looks like a start bit.
   logic sync1_reg;
   logic sync2_reg;
   logic rxs;

   state_t     state_reg, state_next;
   logic [CW-1:0] tick_cnt_reg, tick_cnt_next;
   logic [2:0] bit_idx_reg, bit_idx_next;
   logic [7:0] shift_reg, shift_next;
   logic       perr_reg, perr_next;
   logic       ferr_reg, ferr_next;

   // Frame format captured at start detection.
   logic [1:0] fmt_bits_reg, fmt_bits_next;
   logic       fmt_par_en_reg, fmt_par_en_next;
   logic       fmt_par_sel_reg, fmt_par_sel_next;
   logic       fmt_stop_reg, fmt_stop_next;

   logic [7:0] rx_data_reg, rx_data_next;
   logic       rx_ready_reg, rx_ready_next;
   logic       parity_err_reg, parity_err_next;
   logic       frame_err_reg, frame_err_next;

   logic [2:0] last_idx;
   logic [7:0] data_mask;
   logic       finish;

   assign rxs      = sync2_reg;
   assign last_idx = 3'd4 + {1'b0, fmt_bits_reg};

   // Bits at or below the last data index belong to the word.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_mask
         assign data_mask[gi] = (gi <= int'(last_idx));
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      tick_cnt_next    = tick_cnt_reg;
      bit_idx_next     = bit_idx_reg;
      shift_next       = shift_reg;
      perr_next        = perr_reg;
      ferr_next        = ferr_reg;
      fmt_bits_next    = fmt_bits_reg;
      fmt_par_en_next  = fmt_par_en_reg;
      fmt_par_sel_next = fmt_par_sel_reg;
      fmt_stop_next    = fmt_stop_reg;
      rx_data_next     = rx_data_reg;
      rx_ready_next    = 1'b0;
      parity_err_next  = parity_err_reg;
      frame_err_next   = frame_err_reg;
      finish           = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (baud_en && !rxs) begin
               state_next       = S_START;
               tick_cnt_next    = '0;
               shift_next       = '0;
               perr_next        = 1'b0;
               ferr_next        = 1'b0;
               fmt_bits_next    = data_bits;
               fmt_par_en_next  = parity_en;
               fmt_par_sel_next = parity_sel;
               fmt_stop_next    = stop_bits;
            end
         end

         S_START: begin
            if (baud_en) begin
               if (tick_cnt_reg == HALF_LAST) begin
                  tick_cnt_next = '0;
                  if (rxs) begin
                     // Line went back high before mid-bit: glitch, not a frame.
                     state_next = S_IDLE;
                  end else begin
                     state_next   = S_DATA;
                     bit_idx_next = '0;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end

         S_DATA: begin
            if (baud_en) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next           = '0;
                  shift_next[bit_idx_reg] = rxs;
                  if (bit_idx_reg == last_idx) begin
                     state_next = fmt_par_en_reg ? S_PARITY : S_STOP1;
                  end else begin
                     bit_idx_next = bit_idx_reg + 3'd1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end

         S_PARITY: begin
            if (baud_en) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next = '0;
                  // Even parity needs total XOR 0, odd needs total XOR 1.
                  perr_next  = ((^(shift_reg & data_mask)) ^ rxs) != ~fmt_par_sel_reg;
                  state_next = S_STOP1;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end

         S_STOP1: begin
            if (baud_en) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next = '0;
                  ferr_next     = ferr_reg | ~rxs;
                  if (fmt_stop_reg) begin
                     state_next = S_STOP2;
                  end else begin
                     state_next = S_DONE;
                     finish     = 1'b1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end

         S_STOP2: begin
            if (baud_en) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next = '0;
                  ferr_next     = ferr_reg | ~rxs;
                  state_next    = S_DONE;
                  finish        = 1'b1;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end

         S_DONE: begin
            // A bad stop bit may mean the line is held low (break): wait for
            // it to return high instead of re-triggering on the low level.
            state_next = ferr_reg ? S_BREAK : S_IDLE;
         end

         S_BREAK: begin
            if (baud_en && rxs) begin
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Results are registered on the final stop-bit tick so that rx_data and
      // the flags are valid in the same cycle as the rx_ready pulse (DONE).
      if (finish) begin
         rx_data_next    = shift_reg & data_mask;
         parity_err_next = perr_reg;
         frame_err_next  = ferr_next;
         rx_ready_next   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg       <= 1'b1;
         sync2_reg       <= 1'b1;
         state_reg       <= S_IDLE;
         tick_cnt_reg    <= '0;
         bit_idx_reg     <= '0;
         shift_reg       <= '0;
         perr_reg        <= 1'b0;
         ferr_reg        <= 1'b0;
         fmt_bits_reg    <= '0;
         fmt_par_en_reg  <= 1'b0;
         fmt_par_sel_reg <= 1'b0;
         fmt_stop_reg    <= 1'b0;
         rx_data_reg     <= '0;
         rx_ready_reg    <= 1'b0;
         parity_err_reg  <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         sync1_reg       <= rx_in;
         sync2_reg       <= sync1_reg;
         state_reg       <= state_next;
         tick_cnt_reg    <= tick_cnt_next;
         bit_idx_reg     <= bit_idx_next;
         shift_reg       <= shift_next;
         perr_reg        <= perr_next;
         ferr_reg        <= ferr_next;
         fmt_bits_reg    <= fmt_bits_next;
         fmt_par_en_reg  <= fmt_par_en_next;
         fmt_par_sel_reg <= fmt_par_sel_next;
         fmt_stop_reg    <= fmt_stop_next;
         rx_data_reg     <= rx_data_next;
         rx_ready_reg    <= rx_ready_next;
         parity_err_reg  <= parity_err_next;
         frame_err_reg   <= frame_err_next;
      end
   end

   assign rx_data    = rx_data_reg;
   assign rx_ready   = rx_ready_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign rx_error   = parity_err_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Self-checking bench for uart_rx_cfg. Serial frames are driven bit by bit with
// exact bit timing (OVERSAMPLE ticks, one tick every TDIV clocks). A table of
// hand-computed frames, several hand-written corner sequences and a batch of
// random frames checked against an arithmetic frame model.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int OS       = 16;
   localparam int TDIV     = 4;
   localparam int BIT_CLKS = OS * TDIV;

   logic       clk;
   logic       rst;
   logic       baud_en;
   logic       rx_in;
   logic [1:0] data_bits;
   logic       parity_en;
   logic       parity_sel;
   logic       stop_bits;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_error;
   logic       parity_err;
   logic       frame_err;

   int tests     = 0;
   int failures  = 0;
   int pulse_cnt = 0;
   int baud_div  = 0;

   logic [7:0] cap_data;
   logic       cap_perr;
   logic       cap_ferr;
   logic       cap_rxerr;

   typedef struct {
      logic [1:0] db;
      logic       pe;
      logic       ps;
      logic       sb;
      logic [7:0] data;
      logic       par;
      logic       s1;
      logic       s2;
      int         gap;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[8];

   uart_rx_cfg #(.OVERSAMPLE(OS)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_en    (baud_en),
      .rx_in      (rx_in),
      .data_bits  (data_bits),
      .parity_en  (parity_en),
      .parity_sel (parity_sel),
      .stop_bits  (stop_bits),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rx_error   (rx_error),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One-clk baud tick every TDIV clocks.
   initial begin
      baud_en = 1'b0;
      forever begin
         @(negedge clk);
         baud_div = (baud_div + 1) % TDIV;
         baud_en  = (baud_div == 0);
      end
   end

   // Capture every completed frame.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_ready === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            cap_data  = rx_data;
            cap_perr  = parity_err;
            cap_ferr  = frame_err;
            cap_rxerr = rx_error;
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: simulation still running after 80000 clocks, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold_bit(input logic v, input int nbits);
      rx_in = v;
      repeat (nbits * BIT_CLKS) @(negedge clk);
   endtask

   task automatic set_fmt(input logic [1:0] db, input logic pe, input logic ps, input logic sb);
      data_bits  = db;
      parity_en  = pe;
      parity_sel = ps;
      stop_bits  = sb;
   endtask

   task automatic send_frame(input logic [1:0] db, input logic pe, input logic ps,
                             input logic sb, input logic [7:0] data, input logic par,
                             input logic s1, input logic s2);
      int n;
      set_fmt(db, pe, ps, sb);
      n = 5 + int'(db);
      hold_bit(1'b0, 1);
      for (int i = 0; i < n; i++) hold_bit(data[i], 1);
      if (pe) hold_bit(par, 1);
      hold_bit(s1, 1);
      if (sb) hold_bit(s2, 1);
   endtask

   task automatic check_frame(input string tag, input int base, input logic [7:0] ed,
                              input logic ep, input logic ef);
      check($sformatf("%s pulses", tag), 32'(pulse_cnt - base), 32'd1);
      check($sformatf("%s rx_data", tag), {24'd0, cap_data}, {24'd0, ed});
      check($sformatf("%s parity_err", tag), {31'd0, cap_perr}, {31'd0, ep});
      check($sformatf("%s frame_err", tag), {31'd0, cap_ferr}, {31'd0, ef});
      check($sformatf("%s rx_error", tag), {31'd0, cap_rxerr}, {31'd0, ep | ef});
      $display("[TB] %s: data=0x%02h perr=%0b ferr=%0b", tag, cap_data, cap_perr, cap_ferr);
   endtask

   task automatic check_outputs_zero(input string tag);
      check($sformatf("%s rx_data", tag), {24'd0, rx_data}, 32'd0);
      check($sformatf("%s rx_ready", tag), {31'd0, rx_ready}, 32'd0);
      check($sformatf("%s rx_error", tag), {31'd0, rx_error}, 32'd0);
      check($sformatf("%s parity_err", tag), {31'd0, parity_err}, 32'd0);
      check($sformatf("%s frame_err", tag), {31'd0, frame_err}, 32'd0);
   endtask

   // Reference model: word is the low N bits; total count of ones over data
   // and parity bit must be even for even parity, odd for odd parity; any
   // stop bit at 0 is a framing error.
   function automatic logic [7:0] model_data(input logic [1:0] db, input logic [7:0] data);
      int n;
      n = 5 + int'(db);
      return data & 8'((1 << n) - 1);
   endfunction

   function automatic logic model_perr(input logic [1:0] db, input logic pe, input logic ps,
                                       input logic [7:0] data, input logic par);
      int ones;
      if (!pe) return 1'b0;
      ones = $countones(model_data(db, data)) + int'(par);
      return (ones % 2) != (ps ? 0 : 1);
   endfunction

   function automatic logic model_ferr(input logic sb, input logic s1, input logic s2);
      return (s1 == 1'b0) || (sb && (s2 == 1'b0));
   endfunction

   initial begin
      int base;
      logic [1:0] r_db;
      logic r_pe, r_ps, r_sb, r_par, r_s1, r_s2;
      logic [7:0] r_data;
      int r_gap;

      //        db     pe    ps    sb    data   par   s1    s2   gap exp_data perr  ferr
      vecs[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
      vecs[2] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b1, 1'b1, 1'b1, 1, 8'h15, 1'b0, 1'b0};
      vecs[3] = '{2'd0, 1'b1, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 1'b1, 1, 8'h15, 1'b1, 1'b0};
      vecs[4] = '{2'd2, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 1, 8'h7F, 1'b0, 1'b0};
      vecs[5] = '{2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b1, 8'h2D, 1'b0, 1'b0, 1'b1, 1, 8'h2D, 1'b0, 1'b1};
      vecs[7] = '{2'd1, 1'b1, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b1, 1, 8'h3F, 1'b0, 1'b0};

      rst   = 1'b1;
      rx_in = 1'b1;
      set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      hold_bit(1'b1, 2);
      check("reset idle pulses", 32'(pulse_cnt), 32'd0);

      // Table-driven frames.
      for (int i = 0; i < 8; i++) begin
         base = pulse_cnt;
         send_frame(vecs[i].db, vecs[i].pe, vecs[i].ps, vecs[i].sb, vecs[i].data,
                    vecs[i].par, vecs[i].s1, vecs[i].s2);
         hold_bit(1'b1, vecs[i].gap);
         check_frame($sformatf("vec%0d", i), base, vecs[i].exp_data,
                     vecs[i].exp_perr, vecs[i].exp_ferr);
      end

      // 7O2 with a bad second stop bit, then the line held low: no new frame
      // until the line returns high and a real start bit arrives.
      base = pulse_cnt;
      send_frame(2'd2, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
      hold_bit(1'b0, 3);
      check_frame("ferr_7o2", base, 8'h41, 1'b0, 1'b1);
      hold_bit(1'b1, 12);
      check("break no extra frame", 32'(pulse_cnt - base), 32'd1);

      // Glitch: four ticks low is a false start; status must not change.
      base  = pulse_cnt;
      rx_in = 1'b0;
      repeat (4 * TDIV) @(negedge clk);
      hold_bit(1'b1, 2);
      check("glitch pulses", 32'(pulse_cnt - base), 32'd0);
      check("glitch rx_data", {24'd0, rx_data}, 32'h41);
      check("glitch frame_err", {31'd0, frame_err}, 32'd1);
      check("glitch parity_err", {31'd0, parity_err}, 32'd0);
      check("glitch rx_error", {31'd0, rx_error}, 32'd1);
      $display("[TB] glitch: pulses=%0d data=0x%02h", pulse_cnt - base, rx_data);

      // A clean frame after the glitch proves the receiver went back to idle.
      base = pulse_cnt;
      send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b1);
      hold_bit(1'b1, 1);
      check_frame("after_glitch", base, 8'h2A, 1'b0, 1'b0);

      // Reset in the middle of an 8-bit frame (data 0xF8). The remaining
      // bits are all high, so they must not form a frame after reset.
      set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
      base = pulse_cnt;
      hold_bit(1'b0, 4);
      rx_in = 1'b1;
      repeat (BIT_CLKS * 3 / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_outputs_zero("midframe_reset");
      hold_bit(1'b1, 5);
      check("midframe_reset pulses", 32'(pulse_cnt - base), 32'd0);
      $display("[TB] midframe_reset: pulses=%0d", pulse_cnt - base);

      base = pulse_cnt;
      send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
      hold_bit(1'b1, 1);
      check_frame("after_reset", base, 8'h5A, 1'b0, 1'b0);

      // Format changed mid-frame: the format seen at the start edge applies.
      base = pulse_cnt;
      set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
      hold_bit(1'b0, 1);
      hold_bit(1'b1, 2);
      data_bits = 2'd0;
      hold_bit(1'b1, 7);
      hold_bit(1'b1, 1);
      check_frame("fmt_latch", base, 8'hFF, 1'b0, 1'b0);
      data_bits = 2'd3;

      // Random frames against the arithmetic model.
      for (int k = 0; k < 20; k++) begin
         r_db   = 2'($urandom_range(0, 3));
         r_pe   = 1'($urandom_range(0, 1));
         r_ps   = 1'($urandom_range(0, 1));
         r_sb   = 1'($urandom_range(0, 1));
         r_data = 8'($urandom);
         r_par  = 1'($urandom_range(0, 1));
         r_s1   = ($urandom_range(0, 5) != 0);
         r_s2   = ($urandom_range(0, 5) != 0);
         r_gap  = int'($urandom_range(1, 2));
         base   = pulse_cnt;
         send_frame(r_db, r_pe, r_ps, r_sb, r_data, r_par, r_s1, r_s2);
         hold_bit(1'b1, r_gap);
         check_frame($sformatf("rand%0d", k), base, model_data(r_db, r_data),
                     model_perr(r_db, r_pe, r_ps, r_data, r_par),
                     model_ferr(r_sb, r_s1, r_s2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
